// File: rtl/psram_pkg.sv
// Shared definitions for the PSRAM SPI target and its initiator:
// opcode constants, field widths, the transaction state enumeration
// and small decode helpers.
package psram_pkg;

    localparam logic [7:0] OP_WRITE     = 8'h02;
    localparam logic [7:0] OP_READ      = 8'h03;
    localparam logic [7:0] OP_FAST_READ = 8'h0B;
    localparam logic [7:0] OP_RST_EN    = 8'h66;
    localparam logic [7:0] OP_RST       = 8'h99;
    localparam logic [7:0] OP_READ_ID   = 8'h9F;

    localparam int CMD_BITS   = 8;
    localparam int ADDR_FIELD = 24;
    localparam int DUMMY_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_READ,
        ST_WRITE,
        ST_ID,
        ST_IGNORE
    } psram_state_t;

    // Where a completed command byte leads: addressed commands collect an
    // address, everything else is swallowed until deselect.
    function automatic psram_state_t state_after_cmd(input logic [7:0] op);
        psram_state_t nxt;
        case (op)
            OP_READ, OP_FAST_READ, OP_WRITE, OP_READ_ID: nxt = ST_ADDR;
            default:                                     nxt = ST_IGNORE;
        endcase
        return nxt;
    endfunction

    // Where the data phase starts once the 24 address bits are in.
    function automatic psram_state_t state_after_addr(input logic [7:0] op);
        psram_state_t nxt;
        case (op)
            OP_FAST_READ: nxt = ST_DUMMY;
            OP_READ:      nxt = ST_READ;
            OP_WRITE:     nxt = ST_WRITE;
            OP_READ_ID:   nxt = ST_ID;
            default:      nxt = ST_IGNORE;
        endcase
        return nxt;
    endfunction

    // Read-ID byte sequence: manufacturer id, known-good-die id, then zeros.
    function automatic logic [7:0] id_byte_sel(input logic [1:0] idx,
                                               input logic [7:0] mfid,
                                               input logic [7:0] kgd);
        logic [7:0] b;
        case (idx)
            2'd0:    b = mfid;
            2'd1:    b = kgd;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Byte index into the ID sequence saturates once the zero tail is reached.
    function automatic logic [1:0] id_idx_next(input logic [1:0] idx);
        return (idx >= 2'd2) ? 2'd2 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer for one asynchronous SPI pin, plus a third flop
// so rising/falling edges of the synchronized level can be detected.
module spi_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [2:0] sr;

    // Shift the pin through the synchronizer and edge-history flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= {3{RESET_VAL}};
        end else begin
            sr <= {sr[1:0], din};
        end
    end

    assign q    = sr[1];
    assign rise = sr[1] & ~sr[2];
    assign fall = ~sr[1] & sr[2];

endmodule

// File: rtl/psram_spi_target.sv
// SPI (mode 0) PSRAM target model: byte-addressed internal memory with
// read, fast read, write, read-ID and the 0x66/0x99 software reset pair.
// Bus timing: the initiator holds mosi valid across each sclk rise, where
// it is sampled; miso is updated after each sclk fall and is valid at the
// following rise. Everything is clocked by clk; the SPI pins are sampled.
module psram_spi_target
    import psram_pkg::*;
#(
    parameter int         ADDR_BITS = 10,
    parameter logic [7:0] MFID      = 8'h0D,
    parameter logic [7:0] KGD       = 8'h5D
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce,
    input  logic         sclk,
    input  logic         mosi,
    output logic         miso,
    output logic         busy,
    output logic [7:0]   last_cmd,
    output logic         sw_rst,
    output psram_state_t dbg_state
);

    localparam int MEM_DEPTH = 1 << ADDR_BITS;

    // Synchronized pins and edges.
    logic ce_s, ce_rise, ce_fall;
    logic sclk_s, sclk_rise, sclk_fall;
    logic mosi_s, mosi_rise, mosi_fall;
    logic sync_unused;

    // Transaction state.
    psram_state_t           state;
    logic [4:0]             bit_cnt;
    logic [7:0]             shift_sr;
    logic [7:0]             opcode;
    logic [ADDR_BITS-1:0]   addr;
    logic [1:0]             id_idx;
    logic                   rst_en_armed;
    logic                   rst_en_pending;

    logic [7:0]             mem [MEM_DEPTH];

    logic [7:0]             rx_byte;
    logic [7:0]             rd_byte;
    logic [7:0]             id_byte;
    logic                   byte_done;
    logic                   mem_we;

    // ce resets to the "selected" level so that, after rst, a transaction
    // already in flight produces no falling edge: the bus is only picked up
    // again once ce has been seen high and then low.
    spi_sync #(.RESET_VAL(1'b0)) u_ce_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (ce),
        .q    (ce_s),
        .rise (ce_rise),
        .fall (ce_fall)
    );

    spi_sync #(.RESET_VAL(1'b0)) u_sclk_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (sclk),
        .q    (sclk_s),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    spi_sync #(.RESET_VAL(1'b0)) u_mosi_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (mosi),
        .q    (mosi_s),
        .rise (mosi_rise),
        .fall (mosi_fall)
    );

    assign sync_unused = ^{ce_rise, sclk_s, mosi_rise, mosi_fall};

    assign rx_byte   = {shift_sr[6:0], mosi_s};
    assign rd_byte   = mem[addr];
    assign id_byte   = id_byte_sel(id_idx, MFID, KGD);
    assign byte_done = (bit_cnt == 5'd7);
    assign mem_we    = !rst && !ce_s && (state == ST_WRITE) && sclk_rise && byte_done;
    assign dbg_state = state;

    // Memory array has no reset so contents survive rst and sw_rst.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr] <= rx_byte;
        end
    end

    // Transaction FSM: bit counting, address capture, miso shifting and
    // the reset-enable arm, all with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            bit_cnt        <= 5'd0;
            shift_sr       <= 8'h00;
            opcode         <= 8'h00;
            addr           <= '0;
            id_idx         <= 2'd0;
            rst_en_armed   <= 1'b0;
            rst_en_pending <= 1'b0;
            miso           <= 1'b0;
            busy           <= 1'b0;
            last_cmd       <= 8'h00;
            sw_rst         <= 1'b0;
        end else begin
            sw_rst <= 1'b0;
            if (ce_s) begin
                // Deselected: end of transaction. The arm only survives a
                // transaction that was exactly one 0x66 byte.
                if (state != ST_IDLE) begin
                    rst_en_armed <= rst_en_pending;
                end
                rst_en_pending <= 1'b0;
                state          <= ST_IDLE;
                bit_cnt        <= 5'd0;
                miso           <= 1'b0;
                busy           <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (ce_fall) begin
                            state          <= ST_CMD;
                            busy           <= 1'b1;
                            bit_cnt        <= 5'd0;
                            miso           <= 1'b0;
                            rst_en_pending <= 1'b0;
                        end
                    end

                    ST_CMD: begin
                        if (sclk_rise) begin
                            shift_sr <= rx_byte;
                            if (byte_done) begin
                                opcode         <= rx_byte;
                                last_cmd       <= rx_byte;
                                bit_cnt        <= 5'd0;
                                addr           <= '0;
                                rst_en_armed   <= 1'b0;
                                rst_en_pending <= (rx_byte == OP_RST_EN);
                                sw_rst         <= (rx_byte == OP_RST) && rst_en_armed;
                                state          <= state_after_cmd(rx_byte);
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end

                    ST_ADDR: begin
                        // High address bits shift out of the top and are lost.
                        if (sclk_rise) begin
                            addr <= {addr[ADDR_BITS-2:0], mosi_s};
                            if (bit_cnt == 5'(ADDR_FIELD - 1)) begin
                                bit_cnt <= 5'd0;
                                id_idx  <= 2'd0;
                                state   <= state_after_addr(opcode);
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end

                    ST_DUMMY: begin
                        if (sclk_rise) begin
                            if (bit_cnt == 5'(DUMMY_BITS - 1)) begin
                                bit_cnt <= 5'd0;
                                state   <= ST_READ;
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end

                    ST_READ: begin
                        // Byte boundary: fetch the next byte and present its MSB.
                        if (sclk_fall) begin
                            if (bit_cnt[2:0] == 3'd0) begin
                                miso     <= rd_byte[7];
                                shift_sr <= {rd_byte[6:0], 1'b0};
                                addr     <= addr + ADDR_BITS'(1);
                            end else begin
                                miso     <= shift_sr[7];
                                shift_sr <= {shift_sr[6:0], 1'b0};
                            end
                            bit_cnt <= {2'b00, bit_cnt[2:0] + 3'd1};
                        end
                    end

                    ST_WRITE: begin
                        // The memory write itself happens in the array block.
                        if (sclk_rise) begin
                            shift_sr <= rx_byte;
                            if (byte_done) begin
                                bit_cnt <= 5'd0;
                                addr    <= addr + ADDR_BITS'(1);
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end

                    ST_ID: begin
                        if (sclk_fall) begin
                            if (bit_cnt[2:0] == 3'd0) begin
                                miso     <= id_byte[7];
                                shift_sr <= {id_byte[6:0], 1'b0};
                                id_idx   <= id_idx_next(id_idx);
                            end else begin
                                miso     <= shift_sr[7];
                                shift_sr <= {shift_sr[6:0], 1'b0};
                            end
                            bit_cnt <= {2'b00, bit_cnt[2:0] + 3'd1};
                        end
                    end

                    ST_IGNORE: begin
                        // Any bit after a lone 0x66 disqualifies it as a reset-enable.
                        miso <= 1'b0;
                        if (sclk_rise) begin
                            rst_en_pending <= 1'b0;
                        end
                    end

                    default: begin
                        state <= ST_IDLE;
                        miso  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_psram_spi_target.sv
// Bench for psram_spi_target: directed and random SPI transactions are run
// through a byte-level model; expected miso bytes go into a queue and a
// monitor compares every received byte as it completes.
`timescale 1ns/1ps
module tb_psram_spi_target;
    import psram_pkg::*;

    localparam int         ADDR_BITS = 10;
    localparam int         MEM_DEPTH = 1 << ADDR_BITS;
    localparam int         HALF      = 8;
    localparam logic [7:0] MFID_M    = 8'h0D;
    localparam logic [7:0] KGD_M     = 8'h5D;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic ce   = 1'b1;
    logic sclk = 1'b0;
    logic mosi = 1'b0;
    logic         miso;
    logic         busy;
    logic [7:0]   last_cmd;
    logic         sw_rst;
    psram_state_t dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0] exp_q[$];
    logic [7:0] txq[$];

    logic [7:0] mem_m   [MEM_DEPTH];
    bit         known_m [MEM_DEPTH];
    logic [7:0] last_m       = 8'h00;
    bit         arm_m        = 1'b0;
    int         sw_exp       = 0;
    int         sw_hi_cycles = 0;

    logic [7:0] mon_sr;
    logic [8:0] mon_e;
    int         mon_cnt = 0;

    psram_spi_target #(
        .ADDR_BITS (ADDR_BITS),
        .MFID      (MFID_M),
        .KGD       (KGD_M)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .sclk      (sclk),
        .mosi      (mosi),
        .miso      (miso),
        .busy      (busy),
        .last_cmd  (last_cmd),
        .sw_rst    (sw_rst),
        .dbg_state (dbg_state)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: assemble miso bytes at sclk rises and compare against the queue.
    always @(posedge sclk or posedge ce) begin
        if (ce) begin
            mon_cnt = 0;
        end else begin
            mon_sr = {mon_sr[6:0], miso};
            mon_cnt++;
            if (mon_cnt == 8) begin
                mon_cnt = 0;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL miso_unexpected: got %0h expected none", mon_sr);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e[8]) check("miso_byte", 32'(mon_sr), 32'(mon_e[7:0]));
                end
            end
        end
    end

    // Count clk cycles with sw_rst high; each pulse must be exactly one.
    always @(negedge clk) begin
        if (sw_rst === 1'b1) sw_hi_cycles++;
    end

    // Driver tasks.
    task automatic spi_select();
        ce = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int nb);
        for (int i = 0; i < nb; i++) begin
            mosi = tx[7-i];
            repeat (HALF) @(negedge clk);
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic spi_deselect();
        repeat (HALF) @(negedge clk);
        ce   = 1'b1;
        mosi = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic hdr(input logic [7:0] op, input logic [23:0] a);
        txq.delete();
        txq.push_back(op);
        txq.push_back(a[23:16]);
        txq.push_back(a[15:8]);
        txq.push_back(a[7:0]);
    endtask

    task automatic op_only(input logic [7:0] op);
        txq.delete();
        txq.push_back(op);
    endtask

    // Run txq as one transaction: model the expected miso bytes and memory
    // effects at byte level, drive it, then check the sideband outputs.
    task automatic run_txn(input int part_bits, input logic [7:0] part_val);
        int n, a, idx;
        logic [7:0] op, d;
        logic chk;
        n  = txq.size();
        op = (n > 0) ? txq[0] : 8'h00;
        a  = 0;
        if (n >= 4) a = int'({txq[1], txq[2], txq[3]}) % MEM_DEPTH;
        for (int i = 0; i < n; i++) begin
            d   = 8'h00;
            chk = 1'b1;
            if (i >= 4) begin
                case (op)
                    8'h03: begin
                        idx = (a + i - 4) % MEM_DEPTH;
                        d   = mem_m[idx];
                        chk = known_m[idx];
                    end
                    8'h0B: begin
                        if (i >= 5) begin
                            idx = (a + i - 5) % MEM_DEPTH;
                            d   = mem_m[idx];
                            chk = known_m[idx];
                        end
                    end
                    8'h02: begin
                        idx          = (a + i - 4) % MEM_DEPTH;
                        mem_m[idx]   = txq[i];
                        known_m[idx] = 1'b1;
                    end
                    8'h9F: d = (i == 4) ? MFID_M : (i == 5) ? KGD_M : 8'h00;
                    default: ;
                endcase
            end
            exp_q.push_back({chk, d});
        end
        if (n > 0) begin
            if (txq[0] == 8'h99 && arm_m) sw_exp++;
            arm_m  = (n == 1) && (part_bits == 0) && (txq[0] == 8'h66);
            last_m = txq[0];
        end else begin
            arm_m = 1'b0;
        end

        spi_select();
        check("busy_selected", 32'(busy), 32'd1);
        for (int i = 0; i < n; i++) spi_bits(txq[i], 8);
        if (part_bits > 0) spi_bits(part_val, part_bits);
        spi_deselect();
        check("last_cmd", 32'(last_cmd), 32'(last_m));
        check("sw_rst_cycles", 32'(sw_hi_cycles), 32'(sw_exp));
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    // Read from 0x10, then rst after the first data byte; the rest of the
    // transaction must read as zeros and nothing must be decoded.
    task automatic rst_mid_read();
        for (int i = 0; i < 4; i++) exp_q.push_back(9'h100);
        exp_q.push_back({known_m[16], mem_m[16]});
        exp_q.push_back(9'h100);
        exp_q.push_back(9'h100);
        hdr(8'h03, 24'h000010);
        spi_select();
        for (int i = 0; i < 4; i++) spi_bits(txq[i], 8);
        spi_bits(8'h00, 8);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("busy_after_rst", 32'(busy), 32'd0);
        check("state_after_rst", 32'(dbg_state), 32'(ST_IDLE));
        spi_bits(8'h03, 8);
        spi_bits(8'h00, 8);
        spi_deselect();
        last_m = 8'h00;
        arm_m  = 1'b0;
        check("last_cmd_after_rst", 32'(last_cmd), 32'(last_m));
        check("sw_rst_after_rst", 32'(sw_hi_cycles), 32'(sw_exp));
    endtask

    // Main stimulus and final report.
    initial begin
        logic [7:0]  op;
        logic [9:0]  low;
        logic [13:0] hi;
        int          nd, part, sel;

        rst = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("reset_miso", 32'(miso), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_last_cmd", 32'(last_cmd), 32'd0);
        check("reset_sw_rst", 32'(sw_rst), 32'd0);
        check("reset_state", 32'(dbg_state), 32'(ST_IDLE));

        // Write/read back, wrap, address truncation.
        hdr(8'h02, 24'h000010); txq.push_back(8'hA5); txq.push_back(8'h3C); run_txn(0, 8'h00);
        hdr(8'h03, 24'h000010); txq.push_back(8'h00); txq.push_back(8'h00); run_txn(0, 8'h00);
        hdr(8'h02, 24'h0003FF); txq.push_back(8'h11); txq.push_back(8'h22); run_txn(0, 8'h00);
        hdr(8'h03, 24'h0003FF); txq.push_back(8'h00); txq.push_back(8'h00); run_txn(0, 8'h00);
        hdr(8'h03, 24'h000000); txq.push_back(8'h00); run_txn(0, 8'h00);
        hdr(8'h03, 24'hFFFC10); txq.push_back(8'h00); run_txn(0, 8'h00);

        // Fast read with dummy byte, read ID.
        hdr(8'h0B, 24'h000010); for (int i = 0; i < 3; i++) txq.push_back(8'h00); run_txn(0, 8'h00);
        hdr(8'h9F, 24'h000000); for (int i = 0; i < 4; i++) txq.push_back(8'h00); run_txn(0, 8'h00);

        // Software reset sequences and an unknown opcode.
        op_only(8'h66); run_txn(0, 8'h00);
        op_only(8'h99); run_txn(0, 8'h00);
        op_only(8'h99); run_txn(0, 8'h00);
        op_only(8'hAB); txq.push_back(8'h55); txq.push_back(8'hFF); run_txn(0, 8'h00);
        op_only(8'h66); run_txn(0, 8'h00);
        hdr(8'h03, 24'h000010); txq.push_back(8'h00); run_txn(0, 8'h00);
        op_only(8'h99); run_txn(0, 8'h00);
        op_only(8'h66); run_txn(3, 8'hE0);
        op_only(8'h99); run_txn(0, 8'h00);
        op_only(8'h66); run_txn(0, 8'h00);
        op_only(8'h99); run_txn(0, 8'h00);

        // Partial write byte is discarded.
        hdr(8'h02, 24'h000010); run_txn(4, 8'hF0);
        hdr(8'h03, 24'h000010); txq.push_back(8'h00); run_txn(0, 8'h00);

        // rst during a read, then recovery on a fresh ce cycle.
        rst_mid_read();
        hdr(8'h03, 24'h000010); txq.push_back(8'h00); txq.push_back(8'h00); run_txn(0, 8'h00);

        // Random transactions.
        for (int t = 0; t < 30; t++) begin
            sel = $urandom_range(0, 7);
            case (sel)
                0:       op = 8'h03;
                1:       op = 8'h0B;
                2, 3:    op = 8'h02;
                4:       op = 8'h9F;
                5:       op = 8'h66;
                6:       op = 8'h99;
                default: op = 8'($urandom_range(0, 255));
            endcase
            part = 0;
            if (op == 8'h03 || op == 8'h0B || op == 8'h02 || op == 8'h9F) begin
                if ($urandom_range(0, 1) == 1) low = 10'h3FC + 10'($urandom_range(0, 7));
                else                           low = 10'h010 + 10'($urandom_range(0, 7));
                hi = 14'($urandom_range(0, 16383));
                hdr(op, {hi, low});
                nd = $urandom_range(1, 4) + ((op == 8'h0B) ? 1 : 0);
                for (int i = 0; i < nd; i++) txq.push_back(8'($urandom_range(0, 255)));
                if (op == 8'h02 && $urandom_range(0, 3) == 0) part = $urandom_range(1, 7);
            end else begin
                op_only(op);
                nd = $urandom_range(0, 1);
                for (int i = 0; i < nd; i++) txq.push_back(8'($urandom_range(0, 255)));
            end
            run_txn(part, 8'($urandom_range(0, 255)));
        end

        repeat (20) @(negedge clk);
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
